// File: rtl/mining_pkg.sv
// ============================================================================
// Module   : mining_pkg
// Purpose  : Shared constants for the mining result path: the mark_counter
//            status encoding seen by the interrupt generator and the default
//            nonce width.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mining_pkg;

    // Default nonce width in bits
    localparam int NW_DEFAULT = 32;

    // mark_counter codes; the irq stage stays quiet only on MARK_IDLE
    localparam logic [1:0] MARK_IDLE = 2'b10;
    localparam logic [1:0] MARK_PEND = 2'b00;
    localparam logic [1:0] MARK_OVF  = 2'b01;
    localparam logic [1:0] MARK_RSVD = 2'b11;

endpackage

`default_nettype wire

// File: rtl/nonce_fifo.sv
// ============================================================================
// Module   : nonce_fifo
// Purpose  : DEPTH x NW nonce storage with read/write pointers and an
//            occupancy counter. Push and pop requests are qualified here.
//            Both acknowledges are combinational so the parent can track
//            what was actually accepted. Flush overrides everything.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nonce_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int NW     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [NW-1:0]     wr_data,
    input  logic              pop,
    input  logic              flush,
    output logic              push_ack,
    output logic              pop_ack,
    output logic              rd_valid,
    output logic [NW-1:0]     rd_data,
    output logic [ADDR_W:0]   cnt,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [NW-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);

    // A push into a full FIFO is still legal when the same cycle pops
    assign pop_ack  = pop & ~empty & ~flush;
    assign push_ack = push & (~full | pop_ack) & ~flush;

    // Storage write; contents are deliberately left intact on reset and flush
    always_ff @(posedge clk) begin
        if (push_ack) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ack;
            if (pop_ack) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
            if (push_ack) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            case ({push_ack, pop_ack})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/nonce_result_buf.sv
// ============================================================================
// Module   : nonce_result_buf
// Purpose  : Buffers golden-nonce hits for host readout. Holds the sticky
//            overflow flag and drives the mark_counter status FSM read by
//            the interrupt generator (irq is raised on any code but IDLE).
// Config   : NONCE_DEDUP_EN - when defined, a hit equal to the last accepted
//            nonce is silently discarded.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nonce_result_buf
    import mining_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int NW     = NW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hit_valid,
    input  logic [NW-1:0]     hit_nonce,
    input  logic              rd_req,
    input  logic              clr,
    output logic              rd_valid,
    output logic [NW-1:0]     rd_data,
    output logic [ADDR_W:0]   cnt,
    output logic              ovf,
    output logic [1:0]        mark_counter
);

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    logic       dup;
    logic       hit_eff;
    logic       push_ack;
    logic       pop_ack;
    logic       full;
    logic       empty;
    logic       drop;
    logic [1:0] state;
    logic [1:0] state_nxt;

`ifdef NONCE_DEDUP_EN
    logic [NW-1:0] last_nonce;
    logic          last_vld;

    assign dup = last_vld & (hit_nonce == last_nonce);

    // Remember the most recently accepted nonce for repeat suppression
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_nonce <= '0;
            last_vld   <= 1'b0;
        end else if (clr) begin
            last_nonce <= '0;
            last_vld   <= 1'b0;
        end else if (push_ack) begin
            last_nonce <= hit_nonce;
            last_vld   <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign hit_eff = hit_valid & ~dup;

    // A hit is lost only when the FIFO is full and no pop frees a slot
    assign drop = hit_eff & full & ~rd_req & ~clr;

    nonce_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .NW     (NW)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (hit_eff),
        .wr_data  (hit_nonce),
        .pop      (rd_req),
        .flush    (clr),
        .push_ack (push_ack),
        .pop_ack  (pop_ack),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .cnt      (cnt),
        .full     (full),
        .empty    (empty)
    );

    // Sticky overflow flag; draining does not clear it, only clr does
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end

    // Status FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= MARK_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Status FSM next state: clr wins, then a dropped hit, then occupancy
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = MARK_IDLE;
        end else if (drop) begin
            state_nxt = MARK_OVF;
        end else begin
            case (state)
                MARK_IDLE: begin
                    // Non-empty while IDLE cannot normally occur; treat it as pending
                    if (push_ack || !empty) begin
                        state_nxt = MARK_PEND;
                    end
                end
                MARK_PEND: begin
                    if (pop_ack && !push_ack && (cnt == CNT_ONE)) begin
                        state_nxt = MARK_IDLE;
                    end
                end
                MARK_OVF: begin
                    state_nxt = MARK_OVF;
                end
                default: begin
                    state_nxt = MARK_IDLE;
                end
            endcase
        end
    end

    // Status output; the reserved code is never driven
    always_comb begin
        mark_counter = MARK_IDLE;
        case (state)
            MARK_PEND: mark_counter = MARK_PEND;
            MARK_OVF:  mark_counter = MARK_OVF;
            default:   mark_counter = MARK_IDLE;
        endcase
    end

endmodule

`default_nettype wire
